// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronized serial input, mid-bit sampling,
// byte hand-off with done/acknowledge, completion pulse and frame-error reporting.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_rx_finish,
  output logic [7:0] o_rx_data,
  output logic       o_done,
  output logic       o_irq,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  rx_data_n;
  logic        done_n, irq_n, busy_n, frame_err_n;
  logic        rx_meta, rx_s;

  // Synchronizer resets to 1 so a reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift;
      // blocking here would collapse both flops into one.
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_rx_data   <= '0;
      o_done      <= 1'b0;
      o_irq       <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_rx_data   <= rx_data_n;
      o_done      <= done_n;
      o_irq       <= irq_n;
      o_busy      <= busy_n;
      o_frame_err <= frame_err_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n     = state;
    timer_n     = timer;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    rx_data_n   = o_rx_data;
    done_n      = o_done;
    irq_n       = 1'b0;
    busy_n      = o_busy;
    frame_err_n = o_frame_err;

    unique case (state)
      S_IDLE: begin
        timer_n = '0;
        if (!rx_s) begin
          state_n = S_START;
          busy_n  = 1'b1;
        end
      end

      S_START: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          if (!rx_s) begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end else begin
            // Line went high again before mid-start-bit: treat as a glitch.
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      S_DATA: begin
        if (timer == BIT_LAST) begin
          timer_n          = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      S_STOP: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          if (rx_s) begin
            state_n   = S_DONE;
            rx_data_n = shift;
            done_n    = 1'b1;
            irq_n     = 1'b1;
            busy_n    = 1'b0;
          end else begin
            state_n     = S_ERR;
            frame_err_n = 1'b1;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      S_DONE: begin
        timer_n = '0;
        // A new start bit takes priority for the state; done drops either way.
        if (!rx_s) begin
          state_n = S_START;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end else if (i_rx_finish) begin
          state_n = S_IDLE;
          done_n  = 1'b0;
        end
      end

      S_ERR: begin
        timer_n = '0;
        if (rx_s) begin
          state_n     = S_IDLE;
          frame_err_n = 1'b0;
          busy_n      = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 8 clocks per bit: vector table,
// hand-written corner sequences and randomized frames against a byte-level model.
module tb_uart_rx_core;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       i_rx;
  logic       i_rx_finish;
  logic [7:0] o_rx_data;
  logic       o_done;
  logic       o_irq;
  logic       o_busy;
  logic       o_frame_err;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .i_rx_finish (i_rx_finish),
    .o_rx_data   (o_rx_data),
    .o_done      (o_done),
    .o_irq       (o_irq),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: counts completion pulses, captures delivered bytes, watches invariants.
  int         irq_count     = 0;
  int         irq_wide      = 0;
  int         excl_viol     = 0;
  int         done_rise_cyc = 0;
  int         fall_cyc      = 0;
  logic       busy_seen     = 1'b0;
  logic       prev_irq      = 1'b0;
  logic       prev_done     = 1'b0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (o_irq) begin
      if (!prev_irq) begin
        irq_count++;
        rx_q.push_back(o_rx_data);
      end else begin
        irq_wide++;
      end
    end
    if (o_done && !prev_done) done_rise_cyc = cyc;
    if (o_irq && o_frame_err) excl_viol++;
    if (o_done && o_busy)     excl_viol++;
    if (o_busy) busy_seen = 1'b1;
    prev_irq  = o_irq;
    prev_done = o_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = stop_bit;
    tick(CPB);
  endtask

  task automatic pulse_finish();
    i_rx_finish = 1'b1;
    tick(1);
    i_rx_finish = 1'b0;
  endtask

  // Waits (bounded) for the next completion pulse, then acknowledges one cycle later.
  task automatic ack_next();
    int n = 0;
    while (!o_irq && n < 200) begin
      tick(1);
      n++;
    end
    check("ack_wait_irq", 32'(o_irq), 32'd1);
    tick(1);
    pulse_finish();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_irqs;
  } vec_t;

  vec_t       vecs[5];
  int         irq0;
  int         lat;
  int         n;
  int         bad;
  logic [7:0] last_good;
  logic [7:0] rb;
  logic       rstop;
  logic       rack;

  initial begin
    vecs[0] = '{data: 8'h5A, stop: 1'b1, ack: 1'b1, exp_data: 8'h5A, exp_err: 1'b0, exp_irqs: 1};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, ack: 1'b0, exp_data: 8'h5A, exp_err: 1'b1, exp_irqs: 0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, ack: 1'b0, exp_data: 8'h00, exp_err: 1'b0, exp_irqs: 1};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, ack: 1'b1, exp_data: 8'hFF, exp_err: 1'b0, exp_irqs: 1};
    vecs[4] = '{data: 8'h96, stop: 1'b1, ack: 1'b1, exp_data: 8'h96, exp_err: 1'b0, exp_irqs: 1};

    rst_n       = 1'b0;
    i_rx        = 1'b1;
    i_rx_finish = 1'b0;
    tick(3);
    check("rst_data",  32'(o_rx_data),   32'h00);
    check("rst_done",  32'(o_done),      32'd0);
    check("rst_irq",   32'(o_irq),       32'd0);
    check("rst_busy",  32'(o_busy),      32'd0);
    check("rst_ferr",  32'(o_frame_err), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Basic byte: data, single pulse, done held until acknowledge, latency.
    irq0 = irq_count;
    send_frame(8'hA5, 1'b1);
    lat = done_rise_cyc - fall_cyc;
    check("a5_data",    32'(o_rx_data),          32'hA5);
    check("a5_irqs",    32'(irq_count - irq0),   32'd1);
    check("a5_done",    32'(o_done),             32'd1);
    check("a5_ferr",    32'(o_frame_err),        32'd0);
    check("a5_latency", 32'(lat >= CPB/2 + 9*CPB + 2 && lat <= CPB/2 + 9*CPB + 4), 32'd1);
    tick(30);
    check("a5_done_held", 32'(o_done), 32'd1);
    pulse_finish();
    tick(1);
    check("a5_done_ack", 32'(o_done), 32'd0);

    // Vector table.
    for (int i = 0; i < 5; i++) begin
      irq0 = irq_count;
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_data", i), 32'(o_rx_data),        32'(vecs[i].exp_data));
      check($sformatf("vec%0d_ferr", i), 32'(o_frame_err),      32'(vecs[i].exp_err));
      check($sformatf("vec%0d_irqs", i), 32'(irq_count - irq0), 32'(vecs[i].exp_irqs));
      check($sformatf("vec%0d_done", i), 32'(o_done),           32'(!vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i), 32'(o_busy),           32'(vecs[i].exp_err));
      i_rx = 1'b1;
      if (!vecs[i].stop) begin
        tick(6);
        check($sformatf("vec%0d_ferr_clr", i), 32'(o_frame_err), 32'd0);
      end else if (vecs[i].ack) begin
        pulse_finish();
        tick(1);
        check($sformatf("vec%0d_ack", i), 32'(o_done), 32'd0);
      end
    end

    // Frame error followed by a 40-cycle break.
    send_frame(8'h3C, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(o_frame_err && o_busy)) bad++;
      tick(1);
    end
    check("brk_err_busy_held", 32'(bad), 32'd0);
    i_rx = 1'b1;
    n = 0;
    while (o_frame_err && n < 10) begin
      tick(1);
      n++;
    end
    check("brk_clear_delay", 32'(n >= 2 && n <= 3), 32'd1);
    check("brk_busy_clr",    32'(o_busy),    32'd0);
    check("brk_data_kept",   32'(o_rx_data), 32'h96);

    // False start: 3-cycle low glitch.
    tick(4);
    irq0      = irq_count;
    busy_seen = 1'b0;
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    tick(12);
    check("glitch_busy_seen", 32'(busy_seen),          32'd1);
    check("glitch_busy_clr",  32'(o_busy),             32'd0);
    check("glitch_no_done",   32'(o_done),             32'd0);
    check("glitch_no_irq",    32'(irq_count - irq0),   32'd0);

    // Overrun: second byte starts with no acknowledge of the first.
    irq0 = irq_count;
    send_frame(8'h11, 1'b1);
    check("ovr_first_done", 32'(o_done), 32'd1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick(20);
        check("ovr_done_dropped", 32'(o_done),    32'd0);
        check("ovr_busy",         32'(o_busy),    32'd1);
        check("ovr_old_data",     32'(o_rx_data), 32'h11);
      end
    join
    check("ovr_second_data", 32'(o_rx_data),        32'h22);
    check("ovr_second_done", 32'(o_done),           32'd1);
    check("ovr_irqs",        32'(irq_count - irq0), 32'd2);
    pulse_finish();
    tick(2);

    // Reset in the middle of data bit 4; the aborted frame must not complete.
    irq0 = irq_count;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(5 * CPB + CPB / 2);
        rst_n = 1'b0;
        tick(1);
        check("mrst_data", 32'(o_rx_data),   32'h00);
        check("mrst_busy", 32'(o_busy),      32'd0);
        check("mrst_done", 32'(o_done),      32'd0);
        check("mrst_ferr", 32'(o_frame_err), 32'd0);
        tick(2);
        rst_n = 1'b1;
      end
    join
    tick(20);
    check("mrst_no_irq",  32'(irq_count - irq0), 32'd0);
    check("mrst_no_done", 32'(o_done),           32'd0);
    check("mrst_idle",    32'(o_busy),           32'd0);
    send_frame(8'h81, 1'b1);
    check("mrst_81_data", 32'(o_rx_data),        32'h81);
    check("mrst_81_irq",  32'(irq_count - irq0), 32'd1);
    pulse_finish();
    tick(2);

    // Back-to-back 00 / FF, acknowledged one cycle after each completion pulse.
    irq0 = irq_count;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        ack_next();
        ack_next();
      end
    join
    tick(1);
    check("b2b_irqs", 32'(irq_count - irq0), 32'd2);
    check("b2b_first",  32'(rx_q.size() >= 2 ? rx_q[rx_q.size()-2] : 8'hXX), 32'h00);
    check("b2b_second", 32'(rx_q.size() >= 1 ? rx_q[rx_q.size()-1] : 8'hXX), 32'hFF);
    check("b2b_done_ack", 32'(o_done), 32'd0);
    tick(3);

    // Randomized frames against a byte-level model of the receiver.
    last_good = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rack  = 1'($urandom_range(0, 1));
      irq0  = irq_count;
      send_frame(rb, rstop);
      if (rstop) begin
        last_good = rb;
        check($sformatf("rnd%0d_data", k), 32'(o_rx_data),        32'(last_good));
        check($sformatf("rnd%0d_irq", k),  32'(irq_count - irq0), 32'd1);
        check($sformatf("rnd%0d_done", k), 32'(o_done),           32'd1);
        if (rack) pulse_finish();
        tick($urandom_range(0, 4));
      end else begin
        check($sformatf("rnd%0d_ferr", k), 32'(o_frame_err),      32'd1);
        check($sformatf("rnd%0d_kept", k), 32'(o_rx_data),        32'(last_good));
        check($sformatf("rnd%0d_noirq", k), 32'(irq_count - irq0), 32'd0);
        i_rx = 1'b1;
        tick(6);
      end
    end
    if (o_done) pulse_finish();
    tick(4);

    check("inv_irq_width",   32'(irq_wide),  32'd0);
    check("inv_exclusivity", 32'(excl_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port i_rx_finish  input  1  controller acknowledge that o_rx_data was consumed.
REQ-006 SHALL have port o_rx_data  output  8  last received byte.
REQ-007 SHALL have port o_done  output  1  level: valid byte held, awaiting acknowledge.
REQ-008 SHALL have port o_irq  output  1  single-cycle pulse on byte completion.
REQ-009 SHALL have port o_busy  output  1  frame reception in progress.
REQ-010 SHALL have port o_frame_err  output  1  stop bit sampled low.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, DONE, ERR with a 16-bit bit-timer and a 3-bit bit index.
REQ-013 IDLE: on rx_s == 0, SHALL go to START, clear timer, set o_busy = 1 on the next edge.
REQ-014 START: at timer == CLKS_PER_BIT/2 - 1 (integer divide), SHALL resample rx_s; if 0, go to DATA with timer = 0 and index = 0; if 1 (glitch), return to IDLE with o_busy = 0.
REQ-015 DATA: at timer == CLKS_PER_BIT - 1, SHALL sample rx_s into shift bit [index], LSB first, and reset the timer; after index 7, go to STOP.
REQ-016 STOP: at timer == CLKS_PER_BIT - 1, SHALL sample rx_s.
REQ-017 STOP sample 1: SHALL load o_rx_data from the shift register, set o_done = 1, pulse o_irq for exactly 1 cycle, set o_busy = 0, and go to DONE.
REQ-018 STOP sample 0: SHALL leave o_rx_data unchanged, set o_frame_err = 1, keep o_busy = 1, and go to ERR.
REQ-019 ERR: SHALL stay until rx_s == 1, then clear o_frame_err and o_busy and go to IDLE (break condition held indefinitely).
REQ-020 DONE: on i_rx_finish == 1, SHALL clear o_done and go to IDLE.
REQ-021 DONE with rx_s == 0 and no i_rx_finish (new start bit before acknowledge): SHALL clear o_done, go to START, and set o_busy; o_rx_data keeps the old byte until the next STOP success (overrun is visible to the controller as busy while done was set).
REQ-022 DONE with rx_s == 0 and i_rx_finish in the same cycle: acknowledge wins for o_done; the state still goes to START.
REQ-023 i_rx_finish in any state other than DONE SHALL be ignored.
REQ-024 The timer SHALL count from 0 and never wrap; it is cleared on every state change.
REQ-025 o_irq and o_frame_err SHALL never be 1 in the same cycle; o_done and o_busy SHALL never both be 1 except in the single transition cycle of REQ-021 (none permitted).
REQ-026 Latency: o_done rises (CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3) ±1 cycles after the i_rx falling edge, including synchronizer delay.

Reset
REQ-027 During and after reset, SHALL hold: state IDLE, o_rx_data = 8'h00, o_done = 0, o_irq = 0, o_busy = 0, o_frame_err = 0, timer = 0, index = 0, synchronizer = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block SHALL wait for a new falling edge and SHALL NOT resume the aborted frame.

Verification (CLKS_PER_BIT = 8)
REQ-029 Send byte 8'hA5 with a valid stop bit -> o_rx_data = 8'hA5, o_irq high for 1 cycle, o_done held until i_rx_finish, o_frame_err = 0.
REQ-030 Send 8'h3C with stop bit = 0, then hold i_rx low for 40 cycles -> o_frame_err = 1 and o_busy = 1 for the whole low period; both clear 2-3 cycles after i_rx rises; o_rx_data unchanged.
REQ-031 Pulse i_rx low for 3 cycles -> false start: o_busy returns to 0, and no o_irq or o_done occurs.
REQ-032 Send 8'h11, no acknowledge, then immediately 8'h22 -> o_done drops at the second start bit, then rises again with o_rx_data = 8'h22.
REQ-033 Assert rst_n low during data bit 4 of 8'hFF -> all outputs are 0 and nothing is produced afterward; then send 8'h81 -> received correctly.
REQ-034 Back-to-back 8'h00 and 8'hFF, with i_rx_finish pulsed 1 cycle after each o_irq -> two o_irq pulses and both bytes correct.
